// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined adder/subtractor: one 4-bit carry-lookahead group per stage,
// with skew registers carrying unconsumed operand bits and finished sum bits.
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  cla_adder_pipe_if.slave bus
);
  localparam int G = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;

  // Whole pipeline stalls together, so bubbles keep their slots.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       c4;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ c};
  endfunction

  for (genvar k = 0; k < G; k++) begin : stg
    localparam int RW = WIDTH - 4 * (k + 1);

    logic           v_in;
    logic           c_in;
    logic [3:0]     ga;
    logic [3:0]     gb;
    logic [4:0]     grp;
    logic [4*k+3:0] s_d;
    logic           v_q;
    logic           c_q;
    logic [4*k+3:0] s_q;

    if (k == 0) begin : src
      assign v_in = bus.in_valid;
      assign c_in = bus.sub ? 1'b1 : bus.cin;
      assign ga   = bus.a[3:0];
      assign gb   = b_eff[3:0];
      assign s_d  = grp[3:0];
    end else begin : src
      assign v_in = stg[k-1].v_q;
      assign c_in = stg[k-1].c_q;
      assign ga   = stg[k-1].sk.a_q[3:0];
      assign gb   = stg[k-1].sk.b_q[3:0];
      assign s_d  = {grp[3:0], stg[k-1].s_q};
    end

    assign grp = cla4(ga, gb, c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= grp[4];
          s_q <= s_d;
        end
      end
    end

    // Operand bits still owed to later stages; absent after the last group.
    if (k < G - 1) begin : sk
      logic [RW-1:0] a_d;
      logic [RW-1:0] b_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      if (k == 0) begin : up
        assign a_d = bus.a[WIDTH-1:4];
        assign b_d = b_eff[WIDTH-1:4];
      end else begin : up
        assign a_d = stg[k-1].sk.a_q[RW+3:4];
        assign b_d = stg[k-1].sk.b_q[RW+3:4];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign bus.out_valid = stg[G-1].v_q;
  assign bus.sum       = stg[G-1].s_q;
  assign bus.cout      = stg[G-1].c_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed WIDTH=16 vectors and
// corner sequences, plus random streams on WIDTH=4, 8 and 32 instances.
module tb_cla_adder_pipe;
  localparam int W     = 16;
  localparam int G     = W / 4;
  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n;
  bit   rnd_go = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(W)) bus ();
  cla_adder_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [W:0] expq [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    if (sb) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Scoreboard: every delivered result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) chk("unexpected_output", 64'(1), 64'(0));
      else chk("result", 64'({bus.cout, bus.sum}), 64'(expq.pop_front()));
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sb, input logic [W:0] exp, output int tries);
    logic acc;
    tries = 0;
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.cin = ci;
    bus.sub = sb;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) expq.push_back(exp);
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 100);
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (expq.size() != 0 && guard < 64) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk(name, 64'(expq.size()), 64'(0));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  initial begin
    vec_t         tv [14];
    int           tries;
    int           lat;
    int           cnt;
    logic [4:0]   pat;
    logic [W-1:0] xa;
    logic [W-1:0] xb;

    tv[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    tv[1]  = '{16'h1234, 16'h1235, 1'b1, 1'b1, 16'hFFFF, 1'b0};
    tv[2]  = '{16'h1235, 16'h1234, 1'b0, 1'b1, 16'h0001, 1'b1};
    tv[3]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[4]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
    tv[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tv[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tv[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0};
    tv[8]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    tv[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0};
    tv[10] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0};
    tv[11] = '{16'hABCD, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1'b1};
    tv[12] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0};
    tv[13] = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0001, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_sum", 64'(bus.sum), 64'(0));
    chk("reset_cout", 64'(bus.cout), 64'(0));
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time; the first also measures latency.
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, {tv[i].c, tv[i].s}, tries);
      if (i == 0) begin
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 32) begin
          @(negedge clk);
          lat++;
        end
        chk("latency", 64'(lat), 64'(G));
      end
      drain("table_drain");
    end

    // Backpressure: five back-to-back, three stalled cycles at first result.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          xa = 16'h1111 * 16'(i + 1);
          xb = 16'h0F0F + 16'(i);
          drive(xa, xb, 1'b1, i[0], model(xa, xb, 1'b1, i[0]), tries);
        end
      end
      begin
        logic [W-1:0] s_snap;
        logic         c_snap;
        int           g = 0;
        do begin
          @(posedge clk);
          #1;
          g++;
        end while (!bus.out_valid && g < 40);
        chk("bp_first_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b0;
        s_snap = bus.sum;
        c_snap = bus.cout;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
          chk("bp_out_valid_hold", 64'(bus.out_valid), 64'(1));
          chk("bp_sum_hold", 64'(bus.sum), 64'(s_snap));
          chk("bp_cout_hold", 64'(bus.cout), 64'(c_snap));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Bubbles travel through unmerged: out_valid mirrors in_valid, G later.
    pat = 5'b10101;
    for (int i = 0; i < G + 6; i++) begin
      xa = 16'h1000 * 16'(i) + 16'h0101;
      xb = 16'h0202;
      bus.in_valid = (i < 5) ? pat[i] : 1'b0;
      bus.a = xa;
      bus.b = xb;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) expq.push_back(model(xa, xb, 1'b0, 1'b0));
      chk("bubble_out_valid", 64'(bus.out_valid),
          64'((i >= G && i - G < 5) ? pat[i-G] : 1'b0));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain("bubble_drain");

    // Reset with three in flight: outputs clear at once, nothing leaks out.
    for (int i = 0; i < 3; i++) begin
      xa = 16'h0123 + 16'(i);
      drive(xa, 16'h0456, 1'b0, 1'b0, model(xa, 16'h0456, 1'b0, 1'b0), tries);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midreset_sum", 64'(bus.sum), 64'(0));
    chk("midreset_cout", 64'(bus.cout), 64'(0));
    chk("midreset_in_ready", 64'(bus.in_ready), 64'(1));
    expq.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("postreset_in_ready", 64'(bus.in_ready), 64'(1));
    drive(16'h4444, 16'h2222, 1'b1, 1'b0, 17'h06667, tries);
    chk("postreset_first_accept", 64'(tries), 64'(1));
    cnt = 0;
    for (int i = 0; i < 2 * G + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("postreset_result_count", 64'(cnt), 64'(1));
    chk("postreset_queue_empty", 64'(expq.size()), 64'(0));

    rnd_go = 1'b1;
    begin
      int c = 0;
      while (!(rnd[0].done && rnd[1].done && rnd[2].done) && c < 80000) begin
        @(posedge clk);
        c++;
      end
    end
    chk("rnd_w4_done", 64'(rnd[0].done), 64'(1));
    chk("rnd_w8_done", 64'(rnd[1].done), 64'(1));
    chk("rnd_w32_done", 64'(rnd[2].done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : rnd
    localparam int RW = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;

    cla_adder_pipe_if #(.WIDTH(RW)) rb ();
    cla_adder_pipe #(.WIDTH(RW)) rdut (.clk(clk), .rst_n(rst_n), .bus(rb.slave));

    logic [RW:0] rq [$];
    bit          done = 1'b0;

    function automatic logic [RW:0] rmodel(input logic [RW-1:0] x, input logic [RW-1:0] y,
                                           input logic ci, input logic sb);
      if (sb) return {x >= y, x - y};
      return {1'b0, x} + {1'b0, y} + {{RW{1'b0}}, ci};
    endfunction

    initial begin
      int          sent;
      int          got;
      int          cyc;
      logic [31:0] ra;
      logic [31:0] rbv;
      logic [31:0] rc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      rb.in_valid  = 1'b0;
      rb.a         = '0;
      rb.b         = '0;
      rb.cin       = 1'b0;
      rb.sub       = 1'b0;
      rb.out_ready = 1'b0;
      wait (rnd_go);
      @(posedge clk);
      #1;
      while (got < NRAND && cyc < 60000) begin
        ra  = $urandom;
        rbv = $urandom;
        rc  = $urandom;
        rb.in_valid  = (sent < NRAND) && (rc[5:4] != 2'b00);
        rb.a         = ra[RW-1:0];
        rb.b         = rbv[RW-1:0];
        rb.cin       = rc[0];
        rb.sub       = rc[1];
        rb.out_ready = (rc[3:2] != 2'b00);
        @(negedge clk);
        if (rb.out_valid && rb.out_ready) begin
          if (rq.size() == 0) chk("rnd_unexpected", 64'(1), 64'(0));
          else chk("rnd_result", 64'({rb.cout, rb.sum}), 64'(rq.pop_front()));
          got++;
        end
        if (rb.in_valid && rb.in_ready) begin
          rq.push_back(rmodel(rb.a, rb.b, rb.cin, rb.sub));
          sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      rb.in_valid = 1'b0;
      chk("rnd_complete", 64'(got), 64'(NRAND));
      done = 1'b1;
    end
  end
endmodule
